// File: rtl/dmem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_bus_ctrl_if
//
// Groups the signals between the MEM stage, the data-bus controller and the
// 8-bit synchronous data RAM. Signal names keep their original _i/_o suffixes.
// These suffixes describe direction as seen from the controller, so existing
// connections carry over unchanged.
//
// Parameter:
//   ADDR_W       width of the RAM byte address
//
// Signals (direction as seen by the controller):
//   mem_ce_i     in   request valid
//   mem_we_i     in   1 = store, 0 = load
//   mem_addr_i   in   32-bit byte address (word base is addr[31:2])
//   mem_data_i   in   store data, already lane-positioned
//   mem_sel_i    in   store byte-lane mask (ignored for loads)
//   mem_data_o   out  aligned load word, lane k = byte at base+k
//   stall_req_o  out  pipeline must hold the MEM-stage inputs
//   ram_a_o      out  RAM byte address
//   ram_dout_o   out  RAM write byte
//   ram_wr_o     out  RAM write strobe
//   ram_din_i    in   RAM read byte, valid one cycle after its address
//
// Modports:
//   slave   controller view
//   master  environment view (MEM stage plus RAM)
// ---------------------------------------------------------------------------
interface dmem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_data_i;
    logic [3:0]        mem_sel_i;
    logic [31:0]       mem_data_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i, ram_din_i,
        output mem_data_o, stall_req_o, ram_a_o, ram_dout_o, ram_wr_o
    );

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i, ram_din_i,
        input  mem_data_o, stall_req_o, ram_a_o, ram_dout_o, ram_wr_o
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_bus_ctrl
//
// Bridges the MEM stage's 32-bit word requests onto an 8-bit synchronous
// data RAM.
//   - A load reads the four bytes of the aligned word in turn and returns the
//     reassembled word.
//   - A store writes only the selected byte lanes, one lane per cycle, from
//     lowest to highest.
//   - stall_req_o holds the pipeline until the access completes.
//
// Ports:
//   clk   clock; all state updates on the rising edge
//   rst   asynchronous, active-low reset
//   bus   dmem_bus_ctrl_if.slave (MEM-stage request/response and RAM port)
//
// Optional feature (macro DBUS_RD_BUF_EN):
//   A one-word read buffer remembers the last completed load. A repeated
//   load of that word is answered in its first cycle, with no stall and no
//   RAM access. Any store to the buffered word invalidates the buffer.
// ---------------------------------------------------------------------------
module dmem_bus_ctrl #(
    parameter int unsigned ADDR_W = 18
) (
    input  logic           clk,
    input  logic           rst,
    dmem_bus_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Captured request. The base is word aligned, so it is kept as a word
    // address; base+k then concatenates the lane index and can never carry.
    logic [ADDR_W-1:2] wbase_q;
    logic [31:0]       wdata_q;
    logic [3:0]        sel_q, sel_d;
    logic [1:0]        k_q;

    // asm_q collects lanes 0..2 while a load is in flight. word_q changes only
    // when the last byte arrives, so mem_data_o never shows a partial word.
    logic [23:0]       asm_q;
    logic [31:0]       word_q;

    logic              null_store;
    logic              buf_hit;
    logic              start;
    logic [1:0]        lane;

    logic              stall;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;

    // Address bits outside the RAM space and the byte offset do not take part
    // in the access.
    logic              unused_addr;
    assign unused_addr = ^{bus.mem_addr_i[31:ADDR_W], bus.mem_addr_i[1:0]};

    assign null_store = bus.mem_we_i & (bus.mem_sel_i == 4'b0000);
    assign start      = (state_q == IDLE) & bus.mem_ce_i & ~null_store & ~buf_hit;

    // -----------------------------------------------------------------------
    // Optional one-word read buffer
    // -----------------------------------------------------------------------
`ifdef DBUS_RD_BUF_EN
    logic              buf_valid_q;
    logic [ADDR_W-1:2] buf_tag_q;
    logic              tag_match;

    // Compare tags within the RAM address space. Aliased addresses name the
    // same RAM bytes, so they must also hit and invalidate.
    assign tag_match = (bus.mem_addr_i[ADDR_W-1:2] == buf_tag_q);
    assign buf_hit   = (state_q == IDLE) & bus.mem_ce_i & ~bus.mem_we_i &
                       buf_valid_q & tag_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
        end else if ((state_q == IDLE) && bus.mem_ce_i && bus.mem_we_i && tag_match) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == RD_TAIL) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= wbase_q;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Lowest remaining selected lane of a store
    // -----------------------------------------------------------------------
    always_comb begin
        logic found;
        lane  = 2'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel_q[i] && !found) begin
                lane  = 2'(i);
                found = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and bus outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        stall    = 1'b0;
        ram_a    = '0;
        ram_dout = '0;
        ram_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stall combinationally, so the first cycle of a request is
                // already held.
                if (start) begin
                    stall   = 1'b1;
                    state_d = bus.mem_we_i ? WR : RD;
                end
            end
            RD: begin
                stall = 1'b1;
                ram_a = {wbase_q, k_q};
                if (k_q == 2'd3) begin
                    state_d = RD_TAIL;
                end
            end
            RD_TAIL: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            WR: begin
                stall    = 1'b1;
                ram_a    = {wbase_q, lane};
                ram_dout = wdata_q[8*lane +: 8];
                ram_wr   = 1'b1;
                sel_d    = sel_q & ~(4'b0001 << lane);
                if (sel_d == 4'b0000) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The request is still present here; it is complete and is
                // not restarted.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture and load reassembly
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbase_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            k_q     <= '0;
            asm_q   <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wbase_q <= bus.mem_addr_i[ADDR_W-1:2];
                        wdata_q <= bus.mem_data_i;
                        sel_q   <= bus.mem_sel_i;
                        k_q     <= 2'd0;
                    end
                end
                RD: begin
                    k_q <= k_q + 2'd1;
                    // The byte on ram_din_i belongs to the address presented
                    // in the previous cycle.
                    case (k_q)
                        2'd1:    asm_q[7:0]   <= bus.ram_din_i;
                        2'd2:    asm_q[15:8]  <= bus.ram_din_i;
                        2'd3:    asm_q[23:16] <= bus.ram_din_i;
                        default: ;
                    endcase
                end
                RD_TAIL: begin
                    word_q <= {bus.ram_din_i, asm_q};
                end
                WR: begin
                    sel_q <= sel_d;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The read buffer always holds the last completed load, which is the
    // word already in word_q. A hit therefore needs no separate data path.
    assign bus.mem_data_o  = word_q;

    // The IDLE stall term depends on mem_ce_i, so it is gated to keep the
    // output low while reset is asserted.
    assign bus.stall_req_o = stall & rst;
    assign bus.ram_a_o     = ram_a;
    assign bus.ram_dout_o  = ram_dout;
    assign bus.ram_wr_o    = ram_wr;

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

- Sits between the MEM stage and an 8-bit synchronous data RAM.
- Takes the MEM stage's 32-bit word request (address, write data, write enable, chip enable, 4-bit byte select) and turns it into a sequence of single-byte RAM accesses.
- For loads, it reassembles the aligned 32-bit word and returns it on the MEM stage's read-data input.
- Holds the pipeline through a stall request until the access completes.

## Interface
Parameters:
- ADDR_W, 18, width of the byte address driven to the RAM.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- mem_ce_i  in  1  request valid (from MEM stage mem_ce_o).
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  byte address; the access uses word base {mem_addr_i[31:2],2'b00}.
- mem_data_i  in  32  store data, already lane-positioned.
- mem_sel_i  in  4  store byte-lane mask; ignored for loads.
- mem_data_o  out  32  load word, aligned; lane k = byte at base+k.
- stall_req_o  out  1  1 = pipeline must hold the MEM-stage inputs stable.
- ram_a_o  out  ADDR_W  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write strobe.
- ram_din_i  in  8  RAM read byte; valid the cycle after its address is presented.

## Operation
States: IDLE, RD, RD_TAIL, WR, DONE.

- **IDLE**
  - With mem_ce_i=1, capture base, we, data and sel.
  - Load → RD with lane index k=0.
  - Store with sel≠0 → WR.
  - Store with sel=0 → no access, no stall, stay in IDLE.
- **RD**
  - Drive ram_a_o = (base+k) mod 2^ADDR_W, ram_wr_o=0.
  - For k≥1, capture ram_din_i into lane k-1.
  - After k=3 → RD_TAIL.
- **RD_TAIL**
  - Capture ram_din_i into lane 3 → DONE.
- **WR**
  - Each cycle, issue the lowest remaining selected lane j: ram_a_o=base+j, ram_dout_o=data[8j+7:8j], ram_wr_o=1.
  - Clear bit j; when no bits remain → DONE.
- **DONE**
  - stall_req_o=0.
  - mem_data_o holds the assembled word (loads).
  - → IDLE unconditionally. The request still present this cycle is not restarted.

Stall and bus outputs:
- stall_req_o = (IDLE & mem_ce_i & ~(mem_we_i & mem_sel_i==0) & ~hit) | RD | RD_TAIL | WR.
- This term is combinational so the request is held in its first cycle.
- Input changes during RD/RD_TAIL/WR are ignored; the captured values are used.
- Outside RD/WR: ram_a_o=0, ram_dout_o=0, ram_wr_o=0.
- mem_data_o keeps the last assembled word until the next load completes.

Reset:
- Every output is 0 during reset.
- State → IDLE; the read buffer is invalidated.
- Reset mid-transaction abandons it. Bytes already written stay written; nothing else is issued.

## Timing
- Load, no buffer hit: stall high for 6 cycles (IDLE, RD×4, RD_TAIL); data valid in DONE, the 7th cycle.
- Store with n selected lanes: stall high for 1+n cycles; DONE follows.
- RAM read latency is exactly 1 cycle; no RAM-side wait states.
- Back-to-back requests: at least one IDLE cycle between DONE and the next capture.
- Address wrap: base+k is truncated to ADDR_W bits.

## Configuration
DBUS_RD_BUF_EN
- **Defined:**
  - A one-word buffer holds {valid, word address, data} of the last completed load.
  - A load in IDLE whose word address matches a valid entry is a hit: stall_req_o=0, mem_data_o=buffered word in the same cycle, no RAM access, state stays IDLE.
  - Any store to the buffered word address invalidates the entry at store capture.
  - Reset invalidates the entry.
- **Undefined:**
  - Every load takes the full 6-cycle path.
  - hit is constant 0.

## Test plan
- Preload RAM[0x100..0x103]=11,22,33,44; load at 0x102 → stall 6 cycles; ram_a_o 0x100..0x103 on consecutive cycles; mem_data_o=0x44332211 in DONE.
- Store 0xAABBCCDD at 0x200, sel=4'b1010 → exactly 2 write cycles: (0x201,0xCC), (0x203,0xAA); stall 3 cycles; 0x200/0x202 unchanged.
- Store with sel=0 → stall_req_o=0, ram_wr_o never asserted.
- Load at address with bits above ADDR_W set, base 0x3FFFC (ADDR_W=18) → addresses 0x3FFFC..0x3FFFF; no carry out.
- Drive rst=0 mid-WR after the first of 4 lanes → outputs 0 immediately; only lane 0 written; the next request starts cleanly from IDLE.
- With DBUS_RD_BUF_EN: repeat a load of 0x100 → 0 stall cycles, same data; store sel=4'b0001 to 0x100, then load 0x100 → full 6-cycle path returns new byte 0.
